// File: rtl/nonce_result_scanner.sv
// Reads back NUM_NONCES hash words over the shared memory port, tracks the
// smallest (lowest index on ties) and writes a {hash, nonce, found} record.
module nonce_result_scanner #(
   parameter int NUM_NONCES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] hash_addr,
   input  logic [15:0] result_addr,
   input  logic [31:0] target,
   output logic        done,
   output logic        found,
   output logic [31:0] best_nonce,
   output logic [31:0] best_hash,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam int CW = $clog2(NUM_NONCES + 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [31:0] data;
   } mem_req_t;

   state_t          state, state_nxt;
   mem_req_t        req;
   logic [CW-1:0]   issue_cnt;
   logic [CW-1:0]   rd_idx;
   logic            rd_vld;
   logic [1:0]      wr_cnt;
   logic [15:0]     hash_base;
   logic [15:0]     res_base;
   logic [31:0]     target_q;
   logic            issue_done;
   logic            take;
   logic [31:0]     hash_nxt;

   assign mem_clk    = clk;
   assign issue_done = (issue_cnt == CW'(NUM_NONCES));
   // strict compare keeps the earlier index on ties
   assign take       = rd_vld && (mem_read_data < best_hash);
   assign hash_nxt   = take ? mem_read_data : best_hash;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (issue_done) state_nxt = WRITE;
         WRITE:   if (wr_cnt == 2'd2) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req = '0;
      case (state)
         READ: if (!issue_done) req.addr = hash_base + 16'(issue_cnt);
         WRITE: begin
            req.we   = 1'b1;
            req.addr = res_base + {14'b0, wr_cnt};
            case (wr_cnt)
               2'd0:    req.data = best_hash;
               2'd1:    req.data = best_nonce;
               default: req.data = {31'b0, found};
            endcase
         end
         default: req = '0;
      endcase
   end

   assign done           = (state == IDLE);
   assign mem_we         = req.we;
   assign mem_addr       = req.addr;
   assign mem_write_data = req.data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_cnt  <= '0;
         rd_idx     <= '0;
         rd_vld     <= 1'b0;
         wr_cnt     <= 2'd0;
         hash_base  <= 16'd0;
         res_base   <= 16'd0;
         target_q   <= 32'd0;
         best_hash  <= 32'd0;
         best_nonce <= 32'd0;
         found      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               hash_base  <= hash_addr;
               res_base   <= result_addr;
               target_q   <= target;
               best_hash  <= 32'hFFFF_FFFF;
               best_nonce <= 32'd0;
               found      <= 1'b0;
               issue_cnt  <= '0;
               rd_vld     <= 1'b0;
               wr_cnt     <= 2'd0;
            end
            READ: begin
               // read data lags the issued address by one cycle
               rd_vld <= !issue_done;
               rd_idx <= issue_cnt;
               if (!issue_done) issue_cnt <= issue_cnt + 1'b1;
               if (take) begin
                  best_hash  <= mem_read_data;
                  best_nonce <= 32'(rd_idx);
               end
               if (issue_done) found <= (hash_nxt < target_q);
            end
            WRITE: wr_cnt <= wr_cnt + 2'd1;
            default: ;
         endcase
      end
   end

endmodule
